fp_addsub_param: RTL and testbench

//  Parametrised IEEE-754-style floating-point adder/subtractor with valid/ready handshakes.

---
 rtl/fp_addsub_param.sv | 217 +++++++++++++++++++++
 tb/tb_fp_addsub_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_param.sv
// Parametrised floating-point add/subtract: RNE rounding, flush-to-zero, IEEE exception flags.
// Latency 5 cycles from accept to out_valid; one op in flight, result held in OUTPUT until out_ready.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z,
    output logic [3:0]   out_flags,
    output logic         busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] ALIGN  = 3'd2;
    localparam logic [2:0] ADD    = 3'd3;
    localparam logic [2:0] NORM   = 3'd4;
    localparam logic [2:0] ROUND  = 3'd5;
    localparam logic [2:0] OUTPUT = 3'd6;

    localparam int SW   = MAN_W + 3;
    localparam int MAXE = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [2:0]   state;
    logic [W-1:0] a_r, b_r;
    logic         sub_r;

    // unpack stage
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf;
    logic             sp_vld;
    logic [W-1:0]     sp_z;
    logic [3:0]       sp_f;
    logic             u_sa, u_sb, spec_vld;
    logic [EXP_W-1:0] u_ea, u_eb;
    logic [MAN_W:0]   u_ma, u_mb;
    logic [W-1:0]     spec_z;
    logic [3:0]       spec_f;

    always_comb begin
        ea = a_r[W-2:MAN_W];
        eb = b_r[W-2:MAN_W];
        ma = a_r[MAN_W-1:0];
        mb = b_r[MAN_W-1:0];
        sa = a_r[W-1];
        sb = b_r[W-1] ^ sub_r;
        a_nan = (&ea) && (ma != '0);
        b_nan = (&eb) && (mb != '0);
        a_inf = (&ea) && (ma == '0);
        b_inf = (&eb) && (mb == '0);
        sp_vld = 1'b1;
        sp_z   = QNAN;
        sp_f   = 4'b0000;
        if (a_nan || b_nan)
            sp_f = {(a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]), 3'b000};
        else if (a_inf && b_inf && (sa != sb))
            sp_f = 4'b1000;
        else if (a_inf)
            sp_z = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (b_inf)
            sp_z = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            sp_vld = 1'b0;
    end

    // align stage: larger magnitude first, barrel-shift the smaller with sticky collection
    logic             swap;
    logic [MAN_W:0]   sig_l, sig_s;
    logic [EXP_W-1:0] exp_l, exp_s;
    int               dcap;
    logic [2*SW-1:0]  wide;
    logic             al_sign, al_sub, al_negz;
    logic [EXP_W-1:0] al_exp;
    logic [SW:0]      al_big, al_small;

    always_comb begin
        swap  = {u_eb, u_mb} > {u_ea, u_ma};
        sig_l = swap ? u_mb : u_ma;
        sig_s = swap ? u_ma : u_mb;
        exp_l = swap ? u_eb : u_ea;
        exp_s = swap ? u_ea : u_eb;
        dcap  = int'(exp_l) - int'(exp_s);
        if (dcap > SW)
            dcap = SW;
        wide = {sig_s, 2'b00, {SW{1'b0}}} >> dcap;
    end

    // add and normalise
    logic [SW+1:0]    ad_sum;
    logic [EXP_W-1:0] ad_exp;
    logic             ad_sign, ad_negz;
    int               lzc;
    logic [SW:0]      nm;
    logic signed [31:0] ne;
    logic             n_zero, n_sign, n_negz;

    always_comb begin
        lzc = SW + 1;
        for (int i = 0; i <= SW; i++)
            if (ad_sum[i])
                lzc = SW - i;
    end

    // round and final result selection
    logic [MAN_W+1:0]   sig_r;
    logic               rup, inexact;
    logic signed [31:0] exp_f;
    logic [MAN_W-1:0]   man_f;
    logic [W-1:0]       res_z;
    logic [3:0]         res_f;

    always_comb begin
        inexact = nm[2] | nm[1] | nm[0];
        rup     = nm[2] & (nm[1] | nm[0] | nm[3]);
        sig_r   = {1'b0, nm[SW:3]} + {{(MAN_W+1){1'b0}}, rup};
        exp_f   = ne + (sig_r[MAN_W+1] ? 32'sd1 : 32'sd0);
        man_f   = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
        if (spec_vld) begin
            res_z = spec_z;
            res_f = spec_f;
        end else if (n_zero) begin
            res_z = {n_negz, {(W-1){1'b0}}};
            res_f = 4'b0000;
        end else if (exp_f >= MAXE) begin
            res_z = {n_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_f = 4'b0101;
        end else if (exp_f <= 0) begin
            res_z = {n_sign, {(W-1){1'b0}}};
            res_f = 4'b0011;
        end else begin
            res_z = {n_sign, exp_f[EXP_W-1:0], man_f};
            res_f = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_z     <= '0;
            out_flags <= 4'b0000;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state     <= UNPACK;
                    out_flags <= 4'b0000;
                end
                UNPACK: state <= ALIGN;
                ALIGN:  state <= ADD;
                ADD:    state <= NORM;
                NORM:   state <= ROUND;
                ROUND: begin
                    state     <= OUTPUT;
                    out_z     <= res_z;
                    out_flags <= res_f;
                end
                OUTPUT: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // datapath registers need no reset: they are always rewritten before being observed
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            a_r   <= in_a;
            b_r   <= in_b;
            sub_r <= in_sub;
        end
        if (state == UNPACK) begin
            u_sa     <= sa;
            u_sb     <= sb;
            u_ea     <= ea;
            u_eb     <= eb;
            u_ma     <= (ea == '0) ? '0 : {1'b1, ma};
            u_mb     <= (eb == '0) ? '0 : {1'b1, mb};
            spec_vld <= sp_vld;
            spec_z   <= sp_z;
            spec_f   <= sp_f;
        end
        if (state == ALIGN) begin
            al_sign  <= swap ? u_sb : u_sa;
            al_sub   <= u_sa != u_sb;
            al_negz  <= u_sa & u_sb;
            al_exp   <= exp_l;
            al_big   <= {sig_l, 3'b000};
            al_small <= {wide[2*SW-1:SW], |wide[SW-1:0]};
        end
        if (state == ADD) begin
            ad_sum  <= al_sub ? ({1'b0, al_big} - {1'b0, al_small})
                              : ({1'b0, al_big} + {1'b0, al_small});
            ad_exp  <= al_exp;
            ad_sign <= al_sign;
            ad_negz <= al_negz;
        end
        if (state == NORM) begin
            nm     <= ad_sum[SW+1] ? {ad_sum[SW+1:2], ad_sum[1] | ad_sum[0]} : (ad_sum[SW:0] << lzc);
            ne     <= int'(ad_exp) + (ad_sum[SW+1] ? 1 : -lzc);
            n_zero <= ad_sum == '0;
            n_sign <= ad_sign;
            n_negz <= ad_negz;
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUTPUT;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed-vector bench for fp_addsub_param: single precision and half precision instances.
module tb_fp_addsub_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_z;
    logic [3:0]  out_flags;

    logic        h_in_valid = 1'b0, h_in_sub = 1'b0, h_out_ready = 1'b0;
    logic [15:0] h_in_a = '0, h_in_b = '0;
    logic        h_in_ready, h_out_valid, h_busy;
    logic [15:0] h_out_z;
    logic [3:0]  h_out_flags;

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags), .busy(busy)
    );

    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .out_z(h_out_z), .out_flags(h_out_flags), .busy(h_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] z, output logic [3:0] f, output int lat);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        z = out_z; f = out_flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] z, output logic [3:0] f, output int lat);
        int n = 0;
        while (!h_in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_sub = 1'b0;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 0;
        while (!h_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        z = h_out_z; f = h_out_flags;
        h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
        logic [3:0]  f;
    } hvec_t;

    vec_t  vecs[14];
    hvec_t hvecs[2];

    initial begin
        logic [31:0] z;
        logic [15:0] hz;
        logic [3:0]  f;
        int          lat;
        int          seen;

        vecs[0]  = '{32'h433E95C3, 32'h40E80000, 1'b0, 32'h4345D5C3, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[8]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000};
        vecs[9]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000};
        vecs[10] = '{32'h3F800000, 32'h40400000, 1'b0, 32'h40800000, 4'b0000};
        vecs[11] = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
        vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
        vecs[13] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        hvecs[0] = '{16'h3C00, 16'h3C00, 16'h4000, 4'b0000};
        hvecs[1] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_z",     out_z,              32'd0);
        chk("reset_flags",     {28'b0, out_flags}, 32'd0);
        chk("reset_busy",      {31'b0, busy},      32'd0);

        for (int i = 0; i < 14; i++) begin
            run32(vecs[i].a, vecs[i].b, vecs[i].sub, z, f, lat);
            chk($sformatf("vec%0d_z", i), z, vecs[i].z);
            chk($sformatf("vec%0d_flags", i), {28'b0, f}, {28'b0, vecs[i].f});
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_idle_after", i), {31'b0, in_ready}, 32'd1);
        end

        // stall the consumer; in_valid with other data must be ignored meanwhile
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h433E95C3; in_b = 32'h40E80000; in_sub = 1'b0;
        @(posedge clk); #1;
        in_a = 32'h3F800000; in_b = 32'h3F800000;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("stall_latency", lat, 5);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_out_z",     out_z,              32'h4345D5C3);
            chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_release_in_ready",  {31'b0, in_ready},  32'd1);
        chk("stall_release_out_valid", {31'b0, out_valid}, 32'd0);

        // reset while the op sits in ALIGN
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_busy",     {31'b0, busy},     32'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);

        run32(32'h3F800000, 32'h40400000, 1'b0, z, f, lat);
        chk("recover_z",       z,   32'h40800000);
        chk("recover_latency", lat, 5);

        for (int i = 0; i < 2; i++) begin
            run16(hvecs[i].a, hvecs[i].b, hz, f, lat);
            chk($sformatf("half%0d_z", i), {16'b0, hz}, {16'b0, hvecs[i].z});
            chk($sformatf("half%0d_flags", i), {28'b0, f}, {28'b0, hvecs[i].f});
            chk($sformatf("half%0d_latency", i), lat, 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
